line_mem_ctrl: RTL and testbench

Backing line memory and arbiter that sits directly below the L1 caches. It serves 128-bit line refills for the D-cache and the I-cache from a shared line array with a fixed, parameterised latency, and it absorbs D-cache dirty write-backs. It drives the caches' refill data and valid inputs and consumes their request, address and write-back outputs.

---
 rtl/line_mem_ctrl.sv | 103 ++++++++++
 tb/tb_line_mem_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_ctrl.sv
// Shared 128-bit line memory below the L1 caches: round-robin D/I refill
// arbiter with fixed read latency and a non-blocking D-cache write-back port.
module line_mem_ctrl #(
  parameter int    LAT       = 4,
  parameter int    DEPTH     = 1024,
  parameter int    ADDR_W    = 10,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Dc_mem_req,
  input  logic [ADDR_W-1:0] Dc_mem_addr,
  output logic [127:0]      MEM_data_line,
  output logic              MEM_mem_valid,
  input  logic              Dc_wb_we,
  input  logic [ADDR_W-1:0] Dc_wb_addr,
  input  logic [127:0]      Dc_wb_wline,
  input  logic              Ic_mem_req,
  input  logic [ADDR_W-1:0] Ic_mem_addr,
  output logic [127:0]      IF_data_line,
  output logic              IF_mem_valid
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [3:0]        cnt;
  logic              gnt_i;
  logic              i_turn;
  logic              pick_i;
  logic              any_req;
  logic              sample;
  logic [ADDR_W-1:0] addr_q;
  logic [127:0]      rd_line;
  logic [127:0]      mem [DEPTH];

  // i_turn set after a D grant, so a tie goes to the side served less recently
  assign any_req = Dc_mem_req | Ic_mem_req;
  assign pick_i  = Ic_mem_req & (~Dc_mem_req | i_turn);
  assign sample  = (state == BUSY) && (cnt == 4'd0);

  // write-first forwarding when a write-back lands on the line being sampled
  assign rd_line = (Dc_wb_we && (Dc_wb_addr == addr_q)) ?
                   Dc_wb_wline : mem[addr_q];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (any_req) state_n = BUSY;
      BUSY:    if (cnt == 4'd0) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    MEM_mem_valid = (state == RESP) && !gnt_i;
    IF_mem_valid  = (state == RESP) && gnt_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= 4'd0;
      gnt_i  <= 1'b0;
      i_turn <= 1'b0;
      addr_q <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        gnt_i  <= pick_i;
        i_turn <= ~pick_i;
        addr_q <= pick_i ? Ic_mem_addr : Dc_mem_addr;
        cnt    <= 4'(LAT - 1);
      end else if (state == BUSY && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      MEM_data_line <= '0;
      IF_data_line  <= '0;
    end else if (sample) begin
      if (gnt_i) IF_data_line  <= rd_line;
      else       MEM_data_line <= rd_line;
    end
  end

  always_ff @(posedge clk) begin
    if (Dc_wb_we) mem[Dc_wb_addr] <= Dc_wb_wline;
  end

endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: LAT=4 and LAT=1 instances checked against a
// transaction-level model (line array, grant timing, round-robin turn).
module tb_line_mem_ctrl;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          dreq  [2];
  logic [AW-1:0] daddr [2];
  logic          ireq  [2];
  logic [AW-1:0] iaddr [2];
  logic          we;
  logic [AW-1:0] waddr;
  logic [127:0]  wline;
  logic [127:0]  mdl [2];
  logic [127:0]  idl [2];
  logic          mv  [2];
  logic          iv  [2];

  line_mem_ctrl #(.LAT(4)) u_lat4 (
    .clk(clk), .rst(rst),
    .Dc_mem_req(dreq[0]), .Dc_mem_addr(daddr[0]),
    .MEM_data_line(mdl[0]), .MEM_mem_valid(mv[0]),
    .Dc_wb_we(we), .Dc_wb_addr(waddr), .Dc_wb_wline(wline),
    .Ic_mem_req(ireq[0]), .Ic_mem_addr(iaddr[0]),
    .IF_data_line(idl[0]), .IF_mem_valid(iv[0])
  );

  line_mem_ctrl #(.LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .Dc_mem_req(dreq[1]), .Dc_mem_addr(daddr[1]),
    .MEM_data_line(mdl[1]), .MEM_mem_valid(mv[1]),
    .Dc_wb_we(we), .Dc_wb_addr(waddr), .Dc_wb_wline(wline),
    .Ic_mem_req(ireq[1]), .Ic_mem_addr(iaddr[1]),
    .IF_data_line(idl[1]), .IF_mem_valid(iv[1])
  );

  // reference model state
  logic [127:0]  mem_m [1024];
  bit            pend  [2];
  bit            pside [2];
  bit            iturn [2];
  bit            emv   [2];
  bit            eiv   [2];
  int            pacc  [2];
  int            free_at [2];
  logic [AW-1:0] paddr [2];
  logic [127:0]  emd   [2];
  logic [127:0]  eid   [2];
  int edge_n = 0;
  int checks = 0;
  int errors = 0;

  function automatic int lat_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // one clock edge: advance model with the inputs seen at the edge, then
  // let requesters drop on their valid cycle
  task automatic tick();
    @(posedge clk);
    edge_n++;
    if (we) mem_m[waddr] = wline;
    for (int k = 0; k < 2; k++) begin
      emv[k] = 1'b0;
      eiv[k] = 1'b0;
      if (rst) begin
        pend[k] = 1'b0; iturn[k] = 1'b0;
        emd[k] = '0; eid[k] = '0;
        free_at[k] = edge_n + 1;
      end else if (pend[k] && edge_n == pacc[k] + lat_of(k)) begin
        if (pside[k]) begin eid[k] = mem_m[paddr[k]]; eiv[k] = 1'b1; end
        else          begin emd[k] = mem_m[paddr[k]]; emv[k] = 1'b1; end
        pend[k] = 1'b0;
        free_at[k] = edge_n + 2;
      end else if (!pend[k] && edge_n >= free_at[k] &&
                   (dreq[k] || ireq[k])) begin
        pside[k] = ireq[k] && (!dreq[k] || iturn[k]);
        iturn[k] = !pside[k];
        pend[k]  = 1'b1;
        pacc[k]  = edge_n;
        paddr[k] = pside[k] ? iaddr[k] : daddr[k];
      end
    end
    #1;
    we = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (emv[k]) dreq[k] = 1'b0;
      if (eiv[k]) ireq[k] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (mv[k] !== 1'b0 || iv[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_valid k=%0d got %b%b exp 00", k, mv[k], iv[k]);
      end
      checks++;
      if (mdl[k] !== '0 || idl[k] !== '0) begin
        errors++;
        $display("FAIL reset_lines k=%0d got %h/%h exp 0", k, mdl[k], idl[k]);
      end
    end
  endtask

  task automatic preload();
    for (int a = 0; a < 32; a++) begin
      we = 1'b1;
      waddr = AW'(a);
      wline = {$urandom, $urandom, $urandom, $urandom};
      tick();
    end
  endtask

  task automatic test_single_read();
    int start;
    int seen;
    we = 1'b1; waddr = 10'd5; wline = 128'hA;
    tick();
    dreq[0] = 1'b1; daddr[0] = 10'd5;
    start = edge_n + 1;
    seen = -1;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (mv[0] !== emv[0]) begin
        errors++;
        $display("FAIL single_valid cyc=%0d got %b exp %b", c, mv[0], emv[0]);
      end
      checks++;
      if (iv[0] !== 1'b0) begin
        errors++;
        $display("FAIL single_ivalid cyc=%0d got %b exp 0", c, iv[0]);
      end
      if (mv[0] === 1'b1) begin
        seen = edge_n;
        checks++;
        if (mdl[0] !== 128'hA) begin
          errors++;
          $display("FAIL single_data got %h exp %h", mdl[0], 128'hA);
        end
      end
    end
    checks++;
    if (seen != start + 4) begin
      errors++;
      $display("FAIL single_latency got %0d exp %0d", seen, start + 4);
    end
  endtask

  task automatic test_write_read();
    bit got;
    repeat (2) tick();
    we = 1'b1; waddr = 10'd9; wline = 128'hBEEF;
    tick();
    dreq[0] = 1'b1; daddr[0] = 10'd9;
    got = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if (mv[0] !== emv[0]) begin
        errors++;
        $display("FAIL wr_valid cyc=%0d got %b exp %b", c, mv[0], emv[0]);
      end
      if (mv[0] === 1'b1) begin
        got = 1'b1;
        checks++;
        if (mdl[0] !== 128'hBEEF) begin
          errors++;
          $display("FAIL wr_data got %h exp %h", mdl[0], 128'hBEEF);
        end
      end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL wr_timeout got no valid exp one");
    end
  endtask

  task automatic test_simultaneous();
    int dv [2];
    int ivv [2];
    logic [AW-1:0] da [2];
    logic [AW-1:0] ia [2];
    da = '{10'd1, 10'd4};
    ia = '{10'd2, 10'd6};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int p = 0; p < 2; p++) begin
      dv[p] = -1; ivv[p] = -1;
      dreq[0] = 1'b1; daddr[0] = da[p];
      ireq[0] = 1'b1; iaddr[0] = ia[p];
      for (int c = 0; c < 30 && (dreq[0] || ireq[0]); c++) begin
        tick();
        checks++;
        if (mv[0] !== emv[0] || iv[0] !== eiv[0]) begin
          errors++;
          $display("FAIL sim_valid p=%0d got %b%b exp %b%b",
                   p, mv[0], iv[0], emv[0], eiv[0]);
        end
        if (mv[0] === 1'b1) begin
          dv[p] = edge_n;
          checks++;
          if (mdl[0] !== mem_m[da[p]]) begin
            errors++;
            $display("FAIL sim_ddata p=%0d got %h exp %h", p, mdl[0], mem_m[da[p]]);
          end
        end
        if (iv[0] === 1'b1) begin
          ivv[p] = edge_n;
          checks++;
          if (idl[0] !== mem_m[ia[p]]) begin
            errors++;
            $display("FAIL sim_idata p=%0d got %h exp %h", p, idl[0], mem_m[ia[p]]);
          end
        end
      end
      checks++;
      if (dv[p] < 0 || ivv[p] != dv[p] + 4 + 2) begin
        errors++;
        $display("FAIL sim_order p=%0d got d=%0d i=%0d exp i=d+6", p, dv[p], ivv[p]);
      end
      repeat (2) tick();
    end
  endtask

  task automatic test_collision();
    repeat (2) tick();
    we = 1'b1; waddr = 10'd3; wline = 128'h11;
    tick();
    dreq[0] = 1'b1; daddr[0] = 10'd3;
    repeat (4) tick();
    we = 1'b1; waddr = 10'd3; wline = 128'h55;
    tick();
    checks++;
    if (mv[0] !== 1'b1 || mdl[0] !== 128'h55) begin
      errors++;
      $display("FAIL coll_fwd got %b/%h exp 1/%h", mv[0], mdl[0], 128'h55);
    end
    repeat (2) tick();
    dreq[0] = 1'b1; daddr[0] = 10'd3;
    repeat (5) tick();
    checks++;
    if (mv[0] !== 1'b1 || mdl[0] !== 128'h55) begin
      errors++;
      $display("FAIL coll_after got %b/%h exp 1/%h", mv[0], mdl[0], 128'h55);
    end
  endtask

  task automatic test_reset_mid();
    int rst_edge;
    int seen;
    int pulses;
    repeat (2) tick();
    dreq[0] = 1'b1; daddr[0] = 10'd7;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst_edge = edge_n;
    rst = 1'b0;
    checks++;
    if (mv[0] !== 1'b0 || mdl[0] !== '0 || idl[0] !== '0) begin
      errors++;
      $display("FAIL rmid_clear got %b/%h/%h exp 0", mv[0], mdl[0], idl[0]);
    end
    seen = -1; pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (mv[0] === 1'b1) begin
        seen = edge_n; pulses++;
        checks++;
        if (mdl[0] !== mem_m[7]) begin
          errors++;
          $display("FAIL rmid_data got %h exp %h", mdl[0], mem_m[7]);
        end
      end
    end
    checks++;
    if (pulses != 1 || seen != rst_edge + 1 + 4) begin
      errors++;
      $display("FAIL rmid_timing got %0d pulses at %0d exp 1 at %0d",
               pulses, seen, rst_edge + 5);
    end
  endtask

  task automatic test_back_to_back();
    int v [2];
    int nv;
    repeat (2) tick();
    dreq[1] = 1'b1; daddr[1] = 10'd0;
    nv = 0;
    for (int c = 0; c < 20; c++) begin
      we = $urandom_range(1) == 1;
      waddr = AW'($urandom_range(3));
      wline = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if (mv[1] !== emv[1] || iv[1] !== 1'b0) begin
        errors++;
        $display("FAIL b2b_valid cyc=%0d got %b%b exp %b0", c, mv[1], iv[1], emv[1]);
      end
      checks++;
      if (mdl[1] !== emd[1]) begin
        errors++;
        $display("FAIL b2b_data cyc=%0d got %h exp %h", c, mdl[1], emd[1]);
      end
      if (mv[1] === 1'b1 && nv < 2) begin
        v[nv] = edge_n;
        nv++;
        if (nv == 1) begin dreq[1] = 1'b1; daddr[1] = 10'd1; end
      end
    end
    checks++;
    if (nv != 2 || v[1] - v[0] != 1 + 2) begin
      errors++;
      $display("FAIL b2b_spacing got %0d valids exp 2 spaced 3", nv);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (!dreq[k] && $urandom_range(3) == 0) begin
          dreq[k] = 1'b1; daddr[k] = AW'($urandom_range(31));
        end
        if (!ireq[k] && $urandom_range(3) == 0) begin
          ireq[k] = 1'b1; iaddr[k] = AW'($urandom_range(31));
        end
      end
      we = $urandom_range(2) == 0;
      waddr = AW'($urandom_range(31));
      wline = {$urandom, $urandom, $urandom, $urandom};
      tick();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (mv[k] !== emv[k] || iv[k] !== eiv[k]) begin
          errors++;
          $display("FAIL rand_valid k=%0d cyc=%0d got %b%b exp %b%b",
                   k, c, mv[k], iv[k], emv[k], eiv[k]);
        end
        checks++;
        if (mdl[k] !== emd[k]) begin
          errors++;
          $display("FAIL rand_mline k=%0d cyc=%0d got %h exp %h", k, c, mdl[k], emd[k]);
        end
        checks++;
        if (idl[k] !== eid[k]) begin
          errors++;
          $display("FAIL rand_iline k=%0d cyc=%0d got %h exp %h", k, c, idl[k], eid[k]);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    we = 1'b0; waddr = '0; wline = '0;
    for (int k = 0; k < 2; k++) begin
      dreq[k] = 1'b0; ireq[k] = 1'b0;
      daddr[k] = '0; iaddr[k] = '0;
      pend[k] = 1'b0; iturn[k] = 1'b0; free_at[k] = 0;
      emd[k] = '0; eid[k] = '0;
    end
    #1;
    test_reset();
    preload();
    test_single_read();
    test_write_read();
    test_simultaneous();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
